lane_interleaver_l2: RTL and testbench

Four-lane to single-stream interleaver that sits directly upstream of the two-level demux. Each lane owns a small FIFO. A fixed 4-slot round-robin scheduler running on `clk_4f` pops at most one word per cycle and emits it as a 9-bit word, with bit 8 as the valid flag. Slot order is chosen so the downstream demux's even/odd and half-rate splits land each word back on its original lane.

---
 rtl/lane_interleaver_l2_if.sv | 25 ++
 rtl/lane_interleaver_l2.sv | 92 +++++++++
 tb/tb_lane_interleaver_l2.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/lane_interleaver_l2_if.sv
// Lane-side bus of the four-lane interleaver: write strobes and payloads in,
// stream word and per-lane FIFO status out.
interface lane_interleaver_l2_if #(
  parameter int DATA_W = 8
);
  logic [3:0]        push;
  logic [DATA_W-1:0] data_in0;
  logic [DATA_W-1:0] data_in1;
  logic [DATA_W-1:0] data_in2;
  logic [DATA_W-1:0] data_in3;
  logic [DATA_W:0]   out_stream;
  logic [3:0]        full;
  logic [3:0]        empty;
  logic [3:0]        overflow;

  modport master (
    output push, data_in0, data_in1, data_in2, data_in3,
    input  out_stream, full, empty, overflow
  );

  modport slave (
    input  push, data_in0, data_in1, data_in2, data_in3,
    output out_stream, full, empty, overflow
  );
endinterface

// File: rtl/lane_interleaver_l2.sv
// Four-lane to single-stream interleaver: per-lane FIFOs drained by a fixed
// 4-slot round-robin (lanes 0,2,1,3) so the downstream demux restores lane order.
module lane_interleaver_l2 #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_4f,
  input  logic                 reset,
  lane_interleaver_l2_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [1:0]        slot_q;
  logic [1:0]        lane_sel;
  logic [DATA_W:0]   out_q, out_d;
  logic [3:0]        ovf_q;
  logic [3:0]        full_w, empty_w, pop_w, wr_w, drop_w;
  logic [DATA_W-1:0] din  [4];
  logic [DATA_W-1:0] head [4];

  // Bit-swapping the slot index yields the 0,2,1,3 lane order.
  assign lane_sel = {slot_q[0], slot_q[1]};

  assign din[0] = bus.data_in0;
  assign din[1] = bus.data_in1;
  assign din[2] = bus.data_in2;
  assign din[3] = bus.data_in3;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
      logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
      logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
      logic [CNT_W-1:0]  cnt_q, cnt_d;

      assign full_w[gi]  = (cnt_q == CNT_W'(FIFO_DEPTH));
      assign empty_w[gi] = (cnt_q == '0);
      assign pop_w[gi]   = (lane_sel == 2'(gi)) && !empty_w[gi];
      // A full lane still accepts a write in the cycle its head is popped.
      assign wr_w[gi]    = bus.push[gi] && (!full_w[gi] || pop_w[gi]);
      assign drop_w[gi]  = bus.push[gi] && full_w[gi] && !pop_w[gi];
      assign head[gi]    = mem_q[rd_ptr_q];

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_w[gi]) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_w[gi]) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (wr_w[gi] && !pop_w[gi]) cnt_d = cnt_q + CNT_W'(1);
        else if (!wr_w[gi] && pop_w[gi]) cnt_d = cnt_q - CNT_W'(1);
      end

      always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          cnt_q    <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          cnt_q    <= cnt_d;
        end
      end

      always_ff @(posedge clk_4f) begin
        if (wr_w[gi]) mem_q[wr_ptr_q] <= din[gi];
      end
    end
  endgenerate

  assign out_d = pop_w[lane_sel] ? {1'b1, head[lane_sel]} : '0;

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      slot_q <= '0;
      out_q  <= '0;
      ovf_q  <= '0;
    end else begin
      slot_q <= slot_q + 2'd1;
      out_q  <= out_d;
      ovf_q  <= ovf_q | drop_w;
    end
  end

  assign bus.out_stream = out_q;
  assign bus.full       = full_w;
  assign bus.empty      = empty_w;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_lane_interleaver_l2.sv
// Scoreboard bench for lane_interleaver_l2: a queue-based lane model predicts
// each stream word and the FIFO flags; a monitor compares after every edge.
module tb_lane_interleaver_l2;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [8:0] out;
    logic [3:0] full;
    logic [3:0] empty;
    logic [3:0] ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  lane_interleaver_l2_if #(.DATA_W(8)) bus ();

  lane_interleaver_l2 #(.DATA_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk_4f (clk),
    .reset  (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per lane, slot index counted from reset release.
  logic [7:0] mq [4][$];
  int         slot_m;
  logic [3:0] ovf_m;
  int         lane_map [4] = '{0, 2, 1, 3};
  exp_t       exp_q [$];

  int vectors = 0;
  int fails   = 0;

  exp_t mon_e;
  exp_t mon_a;

  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {bus.out_stream, bus.full, bus.empty, bus.overflow};
      vectors++;
      if (mon_a !== mon_e) begin
        fails++;
        $display("FAIL stream t=%0t: got out=%h full=%b empty=%b ovf=%b, expected out=%h full=%b empty=%b ovf=%b",
                 $time, mon_a.out, mon_a.full, mon_a.empty, mon_a.ovf,
                 mon_e.out, mon_e.full, mon_e.empty, mon_e.ovf);
      end else begin
        $display("ok t=%0t out=%h full=%b empty=%b ovf=%b",
                 $time, mon_a.out, mon_a.full, mon_a.empty, mon_a.ovf);
      end
    end
  end

  // Drive one edge's inputs (called between a negedge and the next posedge)
  // and record the response the model predicts for that edge.
  task automatic cycle(input logic [3:0] p, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3);
    logic [7:0] d [4];
    int         lane;
    exp_t       e;
    bus.push     = p;
    bus.data_in0 = d0;
    bus.data_in1 = d1;
    bus.data_in2 = d2;
    bus.data_in3 = d3;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    lane = lane_map[slot_m];
    if (mq[lane].size() > 0) e.out = {1'b1, mq[lane].pop_front()};
    else                     e.out = 9'h000;
    for (int i = 0; i < 4; i++) begin
      if (p[i]) begin
        if (mq[i].size() < DEPTH) mq[i].push_back(d[i]);
        else                      ovf_m[i] = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      e.full[i]  = (mq[i].size() == DEPTH);
      e.empty[i] = (mq[i].size() == 0);
    end
    e.ovf  = ovf_m;
    slot_m = (slot_m + 1) % 4;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic check_now(input string name, input logic [8:0] got, input logic [8:0] want);
    vectors++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end else begin
      $display("ok %s = %h", name, got);
    end
  endtask

  // Assert reset asynchronously, check the immediate reset state, release at a negedge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_now("rst_out_stream", bus.out_stream, 9'h000);
    check_now("rst_empty", {5'd0, bus.empty}, 9'h00F);
    check_now("rst_full", {5'd0, bus.full}, 9'h000);
    check_now("rst_overflow", {5'd0, bus.overflow}, 9'h000);
    for (int i = 0; i < 4; i++) mq[i].delete();
    exp_q.delete();
    ovf_m        = 4'h0;
    slot_m       = 0;
    bus.push     = 4'h0;
    bus.data_in0 = 8'h00;
    bus.data_in1 = 8'h00;
    bus.data_in2 = 8'h00;
    bus.data_in3 = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.push     = 4'h0;
    bus.data_in0 = 8'h00;
    bus.data_in1 = 8'h00;
    bus.data_in2 = 8'h00;
    bus.data_in3 = 8'h00;
    slot_m       = 0;
    ovf_m        = 4'h0;
    #2;
    do_reset();
    idle(4);

    // Slot order: one word per lane in the same cycle.
    cycle(4'hF, 8'h10, 8'h11, 8'h12, 8'h13);
    idle(8);

    // Single-lane stream into lane 1, overrunning its depth.
    for (int k = 0; k < 6; k++) cycle(4'b0010, 8'h00, 8'(8'hA0 + k), 8'h00, 8'h00);
    idle(20);

    // Fill lane 3, then push once more while its head is being popped.
    for (int k = 0; k < 20; k++) begin
      if (mq[3].size() == DEPTH && slot_m == 3) begin
        cycle(4'b1000, 8'h00, 8'h00, 8'h00, 8'h55);
        break;
      end else if (mq[3].size() < DEPTH) begin
        cycle(4'b1000, 8'h00, 8'h00, 8'h00, 8'(8'h30 + k));
      end else begin
        idle(1);
      end
    end
    idle(20);

    // Pointer wrap on lane 2 at the drain rate.
    for (int k = 0; k < 12; k++) begin
      cycle(4'b0100, 8'h00, 8'h00, 8'(k), 8'h00);
      idle(3);
    end
    idle(8);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      cycle(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    idle(20);

    // Mid-stream reset with every lane holding data.
    for (int k = 0; k < 3; k++) cycle(4'hF, 8'(8'hC0 + k), 8'(8'hD0 + k), 8'(8'hE0 + k), 8'(8'hF0 + k));
    @(posedge clk);
    #3;
    do_reset();
    idle(4);
    for (int k = 0; k < 40; k++) begin
      cycle(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    idle(16);

    @(posedge clk);
    #3;
    check_now("scoreboard_drained", 9'(exp_q.size()), 9'h000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
